lfsr_prbs_burst_ctrl: RTL and testbench

- Sequences an external lfsr_prbs_gen instance to emit framed PRBS bursts on an AXI-Stream-style master port.
- Handles burst length, inter-burst gap, burst count and optional per-burst reseed, with start/abort/done control for BERT and link-test harnesses.
- Sits between the generator and the serializer/MAC under test.

---
 rtl/lfsr_prbs_ctrl_pkg.sv | 12 +
 rtl/lfsr_prbs_burst_ctrl.sv | 140 ++++++++++++++
 tb/tb_lfsr_prbs_burst_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_prbs_ctrl_pkg.sv
// Shared definitions for the PRBS burst controller.
package lfsr_prbs_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_DRAIN,
    S_GAP
  } state_t;

endpackage

// File: rtl/lfsr_prbs_burst_ctrl.sv
// Sequences an external PRBS generator into framed AXI-Stream bursts with
// per-burst reseed, inter-burst gap, burst count and start/abort/done control.
module lfsr_prbs_burst_ctrl
  import lfsr_prbs_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned GAP_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic                  cfg_reseed,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  words_sent,
  output logic                  prbs_rst,
  output logic                  prbs_enable,
  input  logic [DATA_WIDTH-1:0] prbs_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  state_t state, next_state;

  logic [LEN_WIDTH-1:0] len_q, loaded;
  logic [GAP_WIDTH-1:0] gap_q, gap_cnt;
  logic [CNT_WIDTH-1:0] cnt_q, burst_cnt;
  logic                 reseed_q, abort_q;

  logic stop, load, hs, last_load, more_bursts;
  logic load_fire, end_abort, end_normal, burst_start;

  assign stop        = abort || abort_q;
  assign hs          = m_axis_tvalid && m_axis_tready;
  assign load        = !m_axis_tvalid || m_axis_tready;
  assign last_load   = (loaded == len_q - LEN_WIDTH'(1));
  assign more_bursts = (cnt_q == '0) ||
                       (({1'b0, burst_cnt} + (CNT_WIDTH+1)'(1)) < {1'b0, cnt_q});
  assign end_abort   = (state != S_IDLE) && stop && load;
  assign end_normal  = (state == S_DRAIN) && hs && !more_bursts && !stop;
  assign burst_start = (next_state == S_SEED || next_state == S_RUN) &&
                       (state != S_SEED) && (state != S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // GAP runs one cycle short because the first RUN cycle is itself idle on
  // the bus; a gap of 0 or 1 therefore goes straight to SEED/RUN.
  always_comb begin
    next_state = state;
    if (end_abort) begin
      next_state = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (start && cfg_len != '0) next_state = cfg_reseed ? S_SEED : S_RUN;
        S_SEED:  next_state = S_RUN;
        S_RUN:   if (load && last_load) next_state = S_DRAIN;
        S_DRAIN: if (hs) begin
          if (!more_bursts)                next_state = S_IDLE;
          else if (gap_q > GAP_WIDTH'(1))  next_state = S_GAP;
          else                             next_state = reseed_q ? S_SEED : S_RUN;
        end
        S_GAP:   if (gap_cnt == gap_q - GAP_WIDTH'(2)) next_state = reseed_q ? S_SEED : S_RUN;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state != S_IDLE);
    prbs_rst    = (state == S_SEED) && !stop;
    load_fire   = (state == S_RUN) && !stop && load;
    prbs_enable = load_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      gap_q      <= '0;
      cnt_q      <= '0;
      reseed_q   <= 1'b0;
      abort_q    <= 1'b0;
      loaded     <= '0;
      gap_cnt    <= '0;
      burst_cnt  <= '0;
      words_sent <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        len_q     <= cfg_len;
        gap_q     <= cfg_gap;
        cnt_q     <= cfg_count;
        reseed_q  <= cfg_reseed;
        burst_cnt <= '0;
      end else if (state == S_DRAIN && hs && cnt_q != '0) begin
        burst_cnt <= burst_cnt + CNT_WIDTH'(1);
      end

      abort_q <= (state != S_IDLE) && stop && !load;
      gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_WIDTH'(1) : '0;

      if (burst_start)    loaded <= '0;
      else if (load_fire) loaded <= loaded + LEN_WIDTH'(1);

      if (burst_start)                    words_sent <= '0;
      else if (hs && words_sent != len_q) words_sent <= words_sent + LEN_WIDTH'(1);

      done    <= end_abort || end_normal || (state == S_IDLE && start && cfg_len == '0);
      aborted <= end_abort;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (load_fire) begin
      m_axis_tdata  <= prbs_data;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= last_load;
    end else if (hs) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_prbs_burst_ctrl.sv
// Bench for lfsr_prbs_burst_ctrl: drives a PRBS31 generator model and checks
// the stream against a scoreboard of expected words.
module tb_lfsr_prbs_burst_ctrl;

  localparam int DW = 8;
  localparam int LW = 16;
  localparam int GW = 8;
  localparam int CW = 8;
  localparam int NW = 16;
  localparam logic [30:0] SEED = 31'h2A5F1C3B;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [GW-1:0] cfg_gap = '0;
  logic [CW-1:0] cfg_count = '0;
  logic          cfg_reseed = 1'b0;
  logic          busy, done, aborted;
  logic [LW-1:0] words_sent;
  logic          prbs_rst, prbs_enable;
  logic [DW-1:0] prbs_data;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;

  always #5 clk = ~clk;

  lfsr_prbs_burst_ctrl #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_WIDTH(GW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_count(cfg_count), .cfg_reseed(cfg_reseed),
    .busy(busy), .done(done), .aborted(aborted), .words_sent(words_sent),
    .prbs_rst(prbs_rst), .prbs_enable(prbs_enable), .prbs_data(prbs_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  // PRBS31 (x^31 + x^28 + 1) generator, 8 bits per word, MSB first
  logic [30:0] g;
  logic        gen_reload = 1'b1;

  function automatic logic [30:0] adv8(input logic [30:0] s);
    for (int i = 0; i < 8; i++) s = {s[29:0], s[30] ^ s[27]};
    return s;
  endfunction

  function automatic logic [DW-1:0] peek8(input logic [30:0] s);
    logic [DW-1:0] w;
    logic          nb;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      nb = s[30] ^ s[27];
      w  = {w[DW-2:0], nb};
      s  = {s[29:0], nb};
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (prbs_rst || gen_reload) g <= SEED;
    else if (prbs_enable)       g <= adv8(g);
  end
  assign prbs_data = peek8(g);

  // Reference bit stream from the recurrence b[n] = b[n-31] ^ b[n-28]
  logic mb [0:31+8*NW-1];

  function automatic logic [DW-1:0] model_word(input int k);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w = {w[DW-2:0], mb[31 + 8*k + i]};
    return w;
  endfunction

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int compared = 0;
  int mismatched = 0;
  int en_count = 0, rst_count = 0, hs_count = 0, valid_count = 0;
  int zrun = 0, last_gap = 0;
  logic          held = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
      zrun = 0;
    end else begin
      en_count  += int'(prbs_enable);
      rst_count += int'(prbs_rst);
      if (m_axis_tvalid) begin
        valid_count++;
        if (held) begin
          compared++;
          if (m_axis_tdata !== held_data || m_axis_tlast !== held_last) begin
            mismatched++;
            $display("FAIL hold_stable: got data=%h last=%b, need data=%h last=%b",
                     m_axis_tdata, m_axis_tlast, held_data, held_last);
          end
        end
        if (zrun > 0) last_gap = zrun;
        zrun = 0;
        if (m_axis_tready) begin
          hs_count++;
          held = 1'b0;
          compared++;
          if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_word: got data=%h last=%b, need no word",
                     m_axis_tdata, m_axis_tlast);
          end else begin
            e_mon = sb.pop_front();
            if (m_axis_tdata !== e_mon.data || m_axis_tlast !== e_mon.last) begin
              mismatched++;
              $display("FAIL stream_word: got data=%h last=%b, need data=%h last=%b",
                       m_axis_tdata, m_axis_tlast, e_mon.data, e_mon.last);
            end
          end
        end else begin
          held      = 1'b1;
          held_data = m_axis_tdata;
          held_last = m_axis_tlast;
        end
      end else begin
        if (held) begin
          compared++;
          mismatched++;
          $display("FAIL valid_dropped: got tvalid=0, need tvalid=1 until handshake");
          held = 1'b0;
        end
        if (busy) zrun++;
        else      zrun = 0;
      end
    end
  end

  task automatic push_words(input int first, input int n, input int len);
    exp_t e;
    for (int k = first; k < first + n; k++) begin
      e.data = model_word(k);
      e.last = ((k - first + 1) % len) == 0;
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic reload_gen();
    @(posedge clk); #1 gen_reload = 1'b1;
    @(posedge clk); #1 gen_reload = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cycles, output logic ab);
    cycles = -1;
    ab = 1'b0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (done) begin
        cycles = i;
        ab = aborted;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    compared++;
    if ({busy, done, aborted, words_sent, prbs_rst, prbs_enable,
         m_axis_tdata, m_axis_tvalid, m_axis_tlast} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got busy=%b done=%b tvalid=%b ws=%0d en=%b rst=%b, need all 0",
               busy, done, m_axis_tvalid, words_sent, prbs_enable, prbs_rst);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 gen_reload = 1'b0;
  endtask

  task automatic test_single_burst();
    int cyc, e0, r0;
    logic ab;
    cfg_len = 16'd4; cfg_count = 8'd1; cfg_gap = 8'd0; cfg_reseed = 1'b1;
    m_axis_tready = 1'b1;
    push_words(0, 4, 4);
    e0 = en_count; r0 = rst_count;
    pulse_start();
    wait_done(50, cyc, ab);
    compared++;
    if (cyc < 0 || ab !== 1'b0) begin
      mismatched++;
      $display("FAIL t1_done: got cycles=%0d aborted=%b, need done with aborted=0", cyc, ab);
    end
    compared++;
    if (en_count - e0 != 4 || rst_count - r0 != 1) begin
      mismatched++;
      $display("FAIL t1_gen_ctrl: got enables=%0d reseeds=%0d, need 4 and 1",
               en_count - e0, rst_count - r0);
    end
    compared++;
    if (sb.size() != 0 || words_sent !== 16'd4) begin
      mismatched++;
      $display("FAIL t1_words: got left=%0d words_sent=%0d, need 0 and 4", sb.size(), words_sent);
    end
  endtask

  task automatic test_gap_bursts();
    int cyc, e0, r0;
    logic ab;
    reload_gen();
    cfg_len = 16'd3; cfg_count = 8'd2; cfg_gap = 8'd5; cfg_reseed = 1'b0;
    m_axis_tready = 1'b1;
    push_words(0, 6, 3);
    e0 = en_count; r0 = rst_count;
    pulse_start();
    wait_done(80, cyc, ab);
    compared++;
    if (cyc < 0 || ab !== 1'b0) begin
      mismatched++;
      $display("FAIL t2_done: got cycles=%0d aborted=%b, need done with aborted=0", cyc, ab);
    end
    compared++;
    if (last_gap != 5) begin
      mismatched++;
      $display("FAIL t2_gap: got %0d idle cycles, need 5", last_gap);
    end
    compared++;
    if (en_count - e0 != 6 || rst_count - r0 != 0 || sb.size() != 0) begin
      mismatched++;
      $display("FAIL t2_counts: got enables=%0d reseeds=%0d left=%0d, need 6, 0, 0",
               en_count - e0, rst_count - r0, sb.size());
    end
  endtask

  task automatic test_backpressure();
    int e0;
    int cyc = -1;
    logic [31:0] rnd = 32'hC0FFEE11;
    cfg_len = 16'd8; cfg_count = 8'd1; cfg_gap = 8'd0; cfg_reseed = 1'b1;
    push_words(0, 8, 8);
    e0 = en_count;
    pulse_start();
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      rnd = rnd ^ (rnd << 13);
      rnd = rnd ^ (rnd >> 17);
      rnd = rnd ^ (rnd << 5);
      #1 m_axis_tready = rnd[3];
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
    m_axis_tready = 1'b1;
    compared++;
    if (cyc < 0 || aborted !== 1'b0) begin
      mismatched++;
      $display("FAIL t3_done: got cycles=%0d aborted=%b, need done with aborted=0", cyc, aborted);
    end
    compared++;
    if (words_sent !== 16'd8 || en_count - e0 != 8 || sb.size() != 0) begin
      mismatched++;
      $display("FAIL t3_counts: got words_sent=%0d enables=%0d left=%0d, need 8, 8, 0",
               words_sent, en_count - e0, sb.size());
    end
  endtask

  task automatic test_abort();
    int cyc, e0, e1, h0;
    logic ab;
    bit ok;
    reload_gen();
    cfg_len = 16'd2; cfg_count = 8'd0; cfg_gap = 8'd3; cfg_reseed = 1'b0;
    m_axis_tready = 1'b1;
    push_words(0, 5, 2);
    e0 = en_count; h0 = hs_count;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hs_count - h0 >= 4) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1 m_axis_tready = 1'b0;
    for (int i = 0; i < 20 && ok; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) break;
    end
    compared++;
    if (!ok || m_axis_tvalid !== 1'b1) begin
      mismatched++;
      $display("FAIL t4_reach_burst3: got tvalid=%b after %0d handshakes, need tvalid=1 after 4",
               m_axis_tvalid, hs_count - h0);
    end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    e1 = en_count;
    repeat (3) @(negedge clk);
    compared++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== model_word(4) || done !== 1'b0) begin
      mismatched++;
      $display("FAIL t4_held: got tvalid=%b data=%h done=%b, need 1, %h, 0",
               m_axis_tvalid, m_axis_tdata, done, model_word(4));
    end
    @(posedge clk); #1 m_axis_tready = 1'b1;
    wait_done(10, cyc, ab);
    compared++;
    if (cyc < 0 || ab !== 1'b1) begin
      mismatched++;
      $display("FAIL t4_aborted: got cycles=%0d aborted=%b, need done with aborted=1", cyc, ab);
    end
    compared++;
    if (en_count != e1 || en_count - e0 != 5 || sb.size() != 0 || words_sent !== 16'd1) begin
      mismatched++;
      $display("FAIL t4_counts: got post_abort_en=%0d enables=%0d left=%0d ws=%0d, need 0, 5, 0, 1",
               en_count - e1, en_count - e0, sb.size(), words_sent);
    end
  endtask

  task automatic test_zero_len();
    int cyc, e0, r0, v0;
    logic ab;
    cfg_len = 16'd0; cfg_count = 8'd1; cfg_gap = 8'd0; cfg_reseed = 1'b1;
    e0 = en_count; r0 = rst_count; v0 = valid_count;
    pulse_start();
    wait_done(5, cyc, ab);
    compared++;
    if (cyc != 1 || ab !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL t5_done: got cycles=%0d aborted=%b busy=%b, need 1, 0, 0", cyc, ab, busy);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (en_count != e0 || rst_count != r0 || valid_count != v0) begin
      mismatched++;
      $display("FAIL t5_quiet: got enables=%0d reseeds=%0d valids=%0d, need 0, 0, 0",
               en_count - e0, rst_count - r0, valid_count - v0);
    end
  endtask

  task automatic test_reset_midburst();
    int cyc, e0, r0;
    logic ab;
    cfg_len = 16'd6; cfg_count = 8'd1; cfg_gap = 8'd0; cfg_reseed = 1'b1;
    m_axis_tready = 1'b1;
    push_words(0, 6, 6);
    pulse_start();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    compared++;
    if ({busy, done, aborted, words_sent, prbs_rst, prbs_enable,
         m_axis_tdata, m_axis_tvalid, m_axis_tlast} !== '0) begin
      mismatched++;
      $display("FAIL t6_async_reset: got busy=%b tvalid=%b data=%h ws=%0d en=%b, need all 0",
               busy, m_axis_tvalid, m_axis_tdata, words_sent, prbs_enable);
    end
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    reload_gen();
    cfg_len = 16'd3; cfg_count = 8'd1; cfg_gap = 8'd0; cfg_reseed = 1'b0;
    push_words(0, 3, 3);
    e0 = en_count; r0 = rst_count;
    pulse_start();
    cfg_len = 16'd7; cfg_reseed = 1'b1; cfg_count = 8'd3;
    pulse_start();
    wait_done(40, cyc, ab);
    compared++;
    if (cyc < 0 || ab !== 1'b0 || words_sent !== 16'd3) begin
      mismatched++;
      $display("FAIL t6_done: got cycles=%0d aborted=%b ws=%0d, need done, 0, 3", cyc, ab, words_sent);
    end
    repeat (5) @(negedge clk);
    compared++;
    if (en_count - e0 != 3 || rst_count != r0 || sb.size() != 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL t6_no_relatch: got enables=%0d reseeds=%0d left=%0d busy=%b, need 3, 0, 0, 0",
               en_count - e0, rst_count - r0, sb.size(), busy);
    end
  endtask

  initial begin
    logic [30:0] sd;
    sd = SEED;
    for (int i = 0; i < 31; i++) mb[30 - i] = sd[i];
    for (int j = 31; j < 31 + 8*NW; j++) mb[j] = mb[j-31] ^ mb[j-28];

    test_reset();
    test_single_burst();
    test_gap_bursts();
    test_backpressure();
    test_abort();
    test_zero_len();
    test_reset_midburst();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, need bench to finish");
    $fatal(1);
  end

endmodule
